pwm_compare_unit: RTL and testbench

- Downstream consumer and direction controller for the team's up/down/load counter.
- Watches the counter value and drives the counter's up, load and parallel-input pins, so the counter becomes either an edge-aligned sawtooth or a center-aligned triangle.
- Compares the count against a double-buffered duty value and produces a complementary PWM pair with dead-time insertion, plus a period-boundary event.

---
 rtl/pwm_compare_unit_pkg.sv | 14 +
 rtl/pwm_compare_unit_if.sv | 29 ++
 rtl/pwm_compare_unit_dead_time.sv | 50 +++++
 rtl/pwm_compare_unit.sv | 129 ++++++++++++
 tb/tb_pwm_compare_unit.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_compare_unit_pkg.sv
// Shared types for the PWM compare unit: the direction FSM states and the
// counting-mode encodings.
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_e;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

endpackage

// File: rtl/pwm_compare_unit_if.sv
// Bundle between the PWM compare unit and its surroundings: run control,
// counter pins, duty handshake and the PWM outputs.
interface pwm_compare_unit_if #(
  parameter int BITS = 4
);
  logic            en;
  logic            mode;
  logic [BITS-1:0] period;
  logic [BITS-1:0] cnt_in;
  logic [BITS-1:0] duty_in;
  logic            duty_valid;
  logic            duty_ready;
  logic            up_out;
  logic            load_out;
  logic [BITS-1:0] load_val;
  logic            pwm_h;
  logic            pwm_l;
  logic            period_evt;

  modport master (
    output en, mode, period, cnt_in, duty_in, duty_valid,
    input  duty_ready, up_out, load_out, load_val, pwm_h, pwm_l, period_evt
  );

  modport slave (
    input  en, mode, period, cnt_in, duty_in, duty_valid,
    output duty_ready, up_out, load_out, load_val, pwm_h, pwm_l, period_evt
  );
endinterface

// File: rtl/pwm_compare_unit_dead_time.sv
// Complementary output stage: turns the registered compare result into a
// high/low PWM pair with DEAD idle cycles inserted after every transition.
module dead_time_gen #(
  parameter int DEAD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_q,
  input  logic run,
  output logic pwm_h,
  output logic pwm_l
);

  localparam int            CW     = (DEAD > 0) ? $clog2(DEAD + 1) : 1;
  localparam logic [CW-1:0] DEAD_C = CW'(DEAD);

  logic          prev_q;
  logic [CW-1:0] dcnt;
  logic [CW-1:0] cnt_eff;
  logic          changed;
  logic          settled;

  // dcnt counts how long raw_q has held its current value, saturating at DEAD
  always_comb begin
    changed = (raw_q != prev_q);
    cnt_eff = changed ? '0 : dcnt;
    settled = (cnt_eff >= DEAD_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      dcnt   <= '0;
      pwm_h  <= 1'b0;
      pwm_l  <= 1'b0;
    end else begin
      prev_q <= raw_q;
      if (!run) begin
        dcnt  <= '0;
        pwm_h <= 1'b0;
        pwm_l <= 1'b0;
      end else begin
        pwm_h <= settled & raw_q;
        pwm_l <= settled & ~raw_q;
        dcnt  <= settled ? DEAD_C : cnt_eff + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pwm_compare_unit.sv
// Direction controller for the up/down/load counter plus duty compare with
// double-buffered duty, dead-time PWM pair and a period-start event.
module pwm_compare_unit
  import pwm_pkg::*;
#(
  parameter int BITS = 4,
  parameter int DEAD = 2
) (
  input logic               clk,
  input logic               rst,
  pwm_compare_unit_if.slave bus
);

  state_e          state_q;
  state_e          state_d;
  logic            mode_q;
  logic [BITS-1:0] cnt;
  logic [BITS-1:0] period;
  logic [BITS-1:0] active_duty;
  logic [BITS-1:0] shadow;
  logic            pending;
  logic            running;
  logic            run_next;
  logic            up_c;
  logic            load_c;
  logic            boundary;
  logic            raw;
  logic            raw_q;
  logic            evt_q;
  logic            pwm_h_w;
  logic            pwm_l_w;

  assign cnt     = bus.cnt_in;
  assign period  = bus.period;
  assign running = (state_q != ST_IDLE);

  // Counter pins must be combinational: the counter acts on them this cycle
  always_comb begin
    state_d = state_q;
    up_c    = 1'b1;
    load_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_c = 1'b1;
        if (bus.en && (period != '0)) state_d = ST_UP;
      end
      ST_UP: begin
        if (mode_q == MODE_EDGE) begin
          load_c = (cnt == period);
        end else begin
          up_c = (cnt != period);
          if (cnt == period) state_d = ST_DOWN;
        end
      end
      ST_DOWN: begin
        up_c = (cnt == '0);
        if (cnt == '0) state_d = ST_UP;
      end
      default: state_d = ST_IDLE;
    endcase
    if (running && (!bus.en || (period == '0))) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_EDGE;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && (state_d == ST_UP)) mode_q <= bus.mode;
    end
  end

  assign bus.up_out   = up_c;
  assign bus.load_out = load_c;
  assign bus.load_val = '0;

  assign boundary = running && (cnt == '0) && up_c;

  // Shadow accepts while free; it moves into the active duty only at a boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_duty <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
    end else if (boundary && pending) begin
      active_duty <= shadow;
      pending     <= 1'b0;
    end else if (bus.duty_valid && !pending) begin
      shadow  <= bus.duty_in;
      pending <= 1'b1;
    end
  end

  assign bus.duty_ready = ~pending;

  assign raw = running && (cnt < active_duty);

  // Compare stage boundary: raw and boundary registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q <= 1'b0;
      evt_q <= 1'b0;
    end else begin
      raw_q <= raw;
      evt_q <= boundary;
    end
  end

  assign bus.period_evt = evt_q;

  // Outputs must already be off in the first IDLE cycle, so gate on next state
  assign run_next = (state_d != ST_IDLE);

  dead_time_gen #(
    .DEAD (DEAD)
  ) u_dead_time (
    .clk   (clk),
    .rst   (rst),
    .raw_q (raw_q),
    .run   (run_next),
    .pwm_h (pwm_h_w),
    .pwm_l (pwm_l_w)
  );

  assign bus.pwm_h = pwm_h_w;
  assign bus.pwm_l = pwm_l_w;

endmodule

// File: tb/tb_pwm_compare_unit.sv
// Bench for pwm_compare_unit with a behavioural up/down/load counter closing
// the loop; directed vectors with hand-derived expectations.
module tb_pwm_compare_unit;
  import pwm_pkg::*;

  localparam int BITS = 4;
  localparam int DEAD = 2;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_compare_unit_if #(.BITS(BITS)) bus ();

  pwm_compare_unit #(
    .BITS (BITS),
    .DEAD (DEAD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // The team's up/down/load counter
  always @(posedge clk or posedge rst) begin
    if (rst)               bus.cnt_in <= '0;
    else if (bus.load_out) bus.cnt_in <= bus.load_val;
    else if (bus.up_out)   bus.cnt_in <= bus.cnt_in + 4'd1;
    else                   bus.cnt_in <= bus.cnt_in - 4'd1;
  end

  typedef struct {
    int en;
    int cnt;
    int up;
    int load;
    int h;
    int l;
    int evt;
    int rdy;
  } vec_t;

  vec_t tv[23];
  int   cseq[10];
  int   cup[10];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_cnt(input int v);
    int n;
    n = 0;
    while ((int'(bus.cnt_in) != v) && (n < 40)) begin
      tick();
      n++;
    end
    chk("wait_cnt", int'(bus.cnt_in), v);
  endtask

  task automatic count_pwm(input int ncyc, output int nh, output int nl);
    nh = 0;
    nl = 0;
    for (int k = 0; k < ncyc; k++) begin
      chk("no_overlap", int'(bus.pwm_h & bus.pwm_l), 0);
      nh += int'(bus.pwm_h);
      nl += int'(bus.pwm_l);
      tick();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pwm_h"}, int'(bus.pwm_h), 0);
    chk({tag, "_pwm_l"}, int'(bus.pwm_l), 0);
    chk({tag, "_evt"}, int'(bus.period_evt), 0);
    chk({tag, "_ready"}, int'(bus.duty_ready), 1);
    chk({tag, "_load"}, int'(bus.load_out), 1);
    chk({tag, "_load_val"}, int'(bus.load_val), 0);
    chk({tag, "_up"}, int'(bus.up_out), 1);
  endtask

  task automatic restart_with_duty(input int per, input int duty);
    rst = 1'b1;
    bus.en = 1'b0;
    tick();
    rst = 1'b0;
    bus.mode = MODE_EDGE;
    bus.period = 4'(per);
    bus.duty_in = 4'(duty);
    bus.duty_valid = 1'b1;
    tick();
    bus.duty_valid = 1'b0;
    bus.en = 1'b1;
  endtask

  initial begin
    int nh, nl, n;

    // Edge mode, period 9, duty 4, DEAD 2: one row per cycle from enable
    //          en cnt up ld  h  l evt rdy
    tv[0]  = '{1, 0, 1, 1, 0, 0, 0, 0};
    tv[1]  = '{1, 0, 1, 0, 0, 0, 0, 0};
    tv[2]  = '{1, 1, 1, 0, 0, 0, 1, 1};
    tv[3]  = '{1, 2, 1, 0, 0, 1, 0, 1};
    tv[4]  = '{1, 3, 1, 0, 0, 0, 0, 1};
    tv[5]  = '{1, 4, 1, 0, 0, 0, 0, 1};
    tv[6]  = '{1, 5, 1, 0, 1, 0, 0, 1};
    tv[7]  = '{1, 6, 1, 0, 0, 0, 0, 1};
    tv[8]  = '{1, 7, 1, 0, 0, 0, 0, 1};
    tv[9]  = '{1, 8, 1, 0, 0, 1, 0, 1};
    tv[10] = '{1, 9, 1, 1, 0, 1, 0, 1};
    tv[11] = '{1, 0, 1, 0, 0, 1, 0, 1};
    tv[12] = '{1, 1, 1, 0, 0, 1, 1, 1};
    tv[13] = '{1, 2, 1, 0, 0, 0, 0, 1};
    tv[14] = '{1, 3, 1, 0, 0, 0, 0, 1};
    tv[15] = '{1, 4, 1, 0, 1, 0, 0, 1};
    tv[16] = '{1, 5, 1, 0, 1, 0, 0, 1};
    tv[17] = '{1, 6, 1, 0, 0, 0, 0, 1};
    tv[18] = '{1, 7, 1, 0, 0, 0, 0, 1};
    tv[19] = '{1, 8, 1, 0, 0, 1, 0, 1};
    tv[20] = '{1, 9, 1, 1, 0, 1, 0, 1};
    tv[21] = '{1, 0, 1, 0, 0, 1, 0, 1};
    tv[22] = '{1, 1, 1, 0, 0, 1, 1, 1};

    // Center mode, period 5: count and direction by phase in the period
    cseq = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 1};
    cup  = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};

    rst = 1'b1;
    bus.en = 1'b0;
    bus.mode = MODE_EDGE;
    bus.period = '0;
    bus.duty_in = '0;
    bus.duty_valid = 1'b0;

    tick();
    chk_reset_outputs("reset");
    tick();
    chk_reset_outputs("reset_hold");

    // Edge-mode table
    rst = 1'b0;
    bus.period = 4'd9;
    bus.duty_in = 4'd4;
    bus.duty_valid = 1'b1;
    tick();
    bus.duty_valid = 1'b0;
    for (int i = 0; i < 23; i++) begin
      chk($sformatf("edge_cnt[%0d]", i), int'(bus.cnt_in), tv[i].cnt);
      chk($sformatf("edge_up[%0d]", i), int'(bus.up_out), tv[i].up);
      chk($sformatf("edge_load[%0d]", i), int'(bus.load_out), tv[i].load);
      chk($sformatf("edge_h[%0d]", i), int'(bus.pwm_h), tv[i].h);
      chk($sformatf("edge_l[%0d]", i), int'(bus.pwm_l), tv[i].l);
      chk($sformatf("edge_evt[%0d]", i), int'(bus.period_evt), tv[i].evt);
      chk($sformatf("edge_rdy[%0d]", i), int'(bus.duty_ready), tv[i].rdy);
      bus.en = tv[i].en[0];
      tick();
    end

    // Duty handshake: 7 mid-period, 3 held while the shadow is full
    wait_cnt(3);
    chk("hs_ready_free", int'(bus.duty_ready), 1);
    bus.duty_in = 4'd7;
    bus.duty_valid = 1'b1;
    tick();
    chk("hs_ready_drop", int'(bus.duty_ready), 0);
    bus.duty_in = 4'd3;
    n = 0;
    while ((bus.cnt_in != 4'd0) && (n < 20)) begin
      chk("hs_stall", int'(bus.duty_ready), 0);
      tick();
      n++;
    end
    chk("hs_boundary_reached", int'(bus.cnt_in), 0);
    chk("hs_stall_at_boundary", int'(bus.duty_ready), 0);
    tick();
    chk("hs_ready_after_transfer", int'(bus.duty_ready), 1);
    tick();
    chk("hs_second_accept", int'(bus.duty_ready), 0);
    chk("hs_cnt2", int'(bus.cnt_in), 2);
    bus.duty_valid = 1'b0;
    count_pwm(8, nh, nl);
    chk("hs_h_cycles_duty7", nh, 5);
    tick();
    chk("hs_ready_after_transfer2", int'(bus.duty_ready), 1);
    tick();
    count_pwm(8, nh, nl);
    chk("hs_h_cycles_duty3", nh, 1);

    // Reset while pwm_l is high drops everything at once
    wait_cnt(9);
    chk("pre_rst_l", int'(bus.pwm_l), 1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_midop");
    bus.en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_hold_l", int'(bus.pwm_l), 0);
      chk("rst_hold_load", int'(bus.load_out), 1);
    end

    // Center mode, period 5
    rst = 1'b0;
    bus.mode = MODE_CENTER;
    bus.period = 4'd5;
    chk("ctr_idle_cnt", int'(bus.cnt_in), 0);
    chk("ctr_idle_load", int'(bus.load_out), 1);
    bus.en = 1'b1;
    for (int i = 1; i < 22; i++) begin
      tick();
      chk($sformatf("ctr_cnt[%0d]", i), int'(bus.cnt_in), cseq[(i - 1) % 10]);
      chk($sformatf("ctr_up[%0d]", i), int'(bus.up_out), cup[(i - 1) % 10]);
      chk($sformatf("ctr_load[%0d]", i), int'(bus.load_out), 0);
      chk($sformatf("ctr_evt[%0d]", i), int'(bus.period_evt), (((i - 1) % 10) == 1) ? 1 : 0);
    end

    // Extremes: duty 0 and duty above period
    restart_with_duty(9, 0);
    repeat (25) tick();
    count_pwm(10, nh, nl);
    chk("duty0_h", nh, 0);
    chk("duty0_l", nl, 10);

    restart_with_duty(9, 15);
    repeat (25) tick();
    count_pwm(10, nh, nl);
    chk("duty15_h", nh, 10);
    chk("duty15_l", nl, 0);

    // Abort at cnt 6, then restart from 0
    restart_with_duty(9, 4);
    wait_cnt(6);
    bus.en = 1'b0;
    tick();
    chk("abort_h", int'(bus.pwm_h), 0);
    chk("abort_l", int'(bus.pwm_l), 0);
    chk("abort_load", int'(bus.load_out), 1);
    chk("abort_up", int'(bus.up_out), 1);
    chk("abort_load_val", int'(bus.load_val), 0);
    tick();
    chk("abort_cnt_held", int'(bus.cnt_in), 0);
    chk("abort_still_idle", int'(bus.load_out), 1);
    bus.en = 1'b1;
    tick();
    chk("restart_cnt0", int'(bus.cnt_in), 0);
    chk("restart_load", int'(bus.load_out), 0);
    tick();
    chk("restart_cnt1", int'(bus.cnt_in), 1);
    chk("restart_evt", int'(bus.period_evt), 1);

    // Abort while the low side is driven
    wait_cnt(9);
    chk("pre_abort_l", int'(bus.pwm_l), 1);
    bus.en = 1'b0;
    tick();
    chk("abort9_h", int'(bus.pwm_h), 0);
    chk("abort9_l", int'(bus.pwm_l), 0);

    // period 0 never leaves IDLE
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.period = 4'd0;
    bus.en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("per0_load", int'(bus.load_out), 1);
      chk("per0_cnt", int'(bus.cnt_in), 0);
      chk("per0_evt", int'(bus.period_evt), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
